// File: rtl/loopback_checker_pkg.sv
// Shared types, default constants and helpers for the connector loopback checker.
package loopback_pkg;

  localparam int unsigned DEF_NUM_CH  = 8;
  localparam int unsigned DEF_CNT_W   = 24;
  localparam int unsigned DEF_TOL     = 4;
  localparam int unsigned DEF_TIMEOUT = 4_000_000;

  // Comparator width: wide enough for any counter up to 32 bits plus a sign-free margin bit.
  localparam int unsigned DIFF_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RISE = 3'd1,
    ST_MEAS_HIGH = 3'd2,
    ST_MEAS_LOW  = 3'd3,
    ST_STUCK     = 3'd4
  } chan_state_e;

  function automatic logic [DIFF_W:0] abs_diff(input logic [DIFF_W-1:0] a,
                                               input logic [DIFF_W-1:0] b);
    logic [DIFF_W:0] ax;
    logic [DIFF_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax >= bx) ? (ax - bx) : (bx - ax);
  endfunction

endpackage

// File: rtl/loopback_checker_if.sv
// Control, stimulus and status bundle between the board controller and the loopback checker.
interface loopback_checker_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 24
);
  logic                      enable;
  logic                      clear_in;
  logic [NUM_CH-1:0]         sig_in;
  logic [NUM_CH*CNT_W-1:0]   exp_period;
  logic [NUM_CH*CNT_W-1:0]   exp_high;
  logic [NUM_CH-1:0]         ch_ok;
  logic [NUM_CH-1:0]         ch_fail;
  logic [NUM_CH-1:0]         ch_stuck;
  logic [NUM_CH-1:0]         eval_stb;

  modport master (
    output enable, clear_in, sig_in, exp_period, exp_high,
    input  ch_ok, ch_fail, ch_stuck, eval_stb
  );

  modport slave (
    input  enable, clear_in, sig_in, exp_period, exp_high,
    output ch_ok, ch_fail, ch_stuck, eval_stb
  );
endinterface

// File: rtl/loopback_checker_chan.sv
// One loopback channel: synchronizer, edge detect, period/high-time measurement FSM and
// tolerance check against the expected waveform.
module loopback_chan
  import loopback_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TOL     = DEF_TOL,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear_in,
  input  logic             sig,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  output logic             ok,
  output logic             fail,
  output logic             stuck,
  output logic             stb
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [DIFF_W:0]   DIFF_TOL = (DIFF_W + 1)'(TOL);

  logic             sync_q;
  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;
  chan_state_e      state;
  chan_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_meas;
  logic [CNT_W-1:0] high_nxt;
  logic             ok_nxt;
  logic             fail_nxt;
  logic             stuck_nxt;
  logic             stb_nxt;
  logic             pass;

  // Two-flop synchronizer plus previous-value copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= sig;
      s      <= sync_q;
      s_d    <= s;
    end
  end

  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_inc = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  // In MEAS_LOW the running count at the closing rise is the measured period.
  assign pass = (abs_diff(DIFF_W'(cnt), DIFF_W'(exp_period)) <= DIFF_TOL) &&
                (abs_diff(DIFF_W'(high_meas), DIFF_W'(exp_high)) <= DIFF_TOL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      high_meas <= '0;
      ok        <= 1'b0;
      fail      <= 1'b0;
      stuck     <= 1'b0;
      stb       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      high_meas <= high_nxt;
      ok        <= ok_nxt;
      fail      <= fail_nxt;
      stuck     <= stuck_nxt;
      stb       <= stb_nxt;
    end
  end

  // Next-state logic; an evaluation overrides a coincident clear.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    high_nxt  = high_meas;
    ok_nxt    = ok;
    fail_nxt  = fail;
    stuck_nxt = stuck;
    stb_nxt   = 1'b0;

    if (clear_in) begin
      ok_nxt   = 1'b0;
      fail_nxt = 1'b0;
    end

    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      stuck_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_WAIT_RISE;
          cnt_nxt   = '0;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            state_nxt = ST_MEAS_HIGH;
            cnt_nxt   = CNT_W'(1);
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_nxt = ST_STUCK;
              stuck_nxt = 1'b1;
            end
          end
        end
        ST_MEAS_HIGH: begin
          cnt_nxt = cnt_inc;
          if (fall) begin
            high_nxt  = cnt;
            state_nxt = ST_MEAS_LOW;
          end else if (cnt_inc == CNT_MAX) begin
            state_nxt = ST_STUCK;
            stuck_nxt = 1'b1;
          end
        end
        ST_MEAS_LOW: begin
          if (rise) begin
            ok_nxt    = pass;
            stb_nxt   = 1'b1;
            if (!pass) fail_nxt = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ST_MEAS_HIGH;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_nxt = ST_STUCK;
              stuck_nxt = 1'b1;
            end
          end
        end
        ST_STUCK: begin
          if (rise) begin
            stuck_nxt = 1'b0;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ST_MEAS_HIGH;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/loopback_checker.sv
// Multi-channel loopback checker: one independent measurement channel per returned signal.
module loopback_checker
  import loopback_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TOL     = DEF_TOL,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  loopback_checker_if.slave bus
);

  logic [NUM_CH-1:0] ok_v;
  logic [NUM_CH-1:0] fail_v;
  logic [NUM_CH-1:0] stuck_v;
  logic [NUM_CH-1:0] stb_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] exp_period_ch;
    logic [CNT_W-1:0] exp_high_ch;

    assign exp_period_ch = bus.exp_period[i*CNT_W +: CNT_W];
    assign exp_high_ch   = bus.exp_high[i*CNT_W +: CNT_W];

    loopback_chan #(
      .CNT_W   (CNT_W),
      .TOL     (TOL),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (bus.enable),
      .clear_in   (bus.clear_in),
      .sig        (bus.sig_in[i]),
      .exp_period (exp_period_ch),
      .exp_high   (exp_high_ch),
      .ok         (ok_v[i]),
      .fail       (fail_v[i]),
      .stuck      (stuck_v[i]),
      .stb        (stb_v[i])
    );
  end

  assign bus.ch_ok    = ok_v;
  assign bus.ch_fail  = fail_v;
  assign bus.ch_stuck = stuck_v;
  assign bus.eval_stb = stb_v;

endmodule

// File: tb/tb_loopback_checker.sv
// Scoreboard bench for loopback_checker: pulse drivers push expected evaluations, a monitor pops them.
module tb_loopback_checker;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned CNT_W   = 24;
  localparam int unsigned TOL     = 4;
  localparam int unsigned TIMEOUT = 1000;

  typedef struct {
    logic ok;
    logic fail;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loopback_checker_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  loopback_checker #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .TOL     (TOL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks;
  int   errors;
  int   first_stb_cyc;
  int   rise2_cyc;
  int   ep        [NUM_CH];
  int   eh        [NUM_CH];
  int   last_rise [NUM_CH];
  int   last_fall [NUM_CH];
  bit   armed     [NUM_CH];
  bit   m_ok      [NUM_CH];
  bit   m_fail    [NUM_CH];
  exp_t sb_q      [NUM_CH][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  task automatic set_exp(input int c, input int p, input int h);
    ep[c] = p;
    eh[c] = h;
    bus.exp_period[c*CNT_W +: CNT_W] = CNT_W'(p);
    bus.exp_high[c*CNT_W +: CNT_W]   = CNT_W'(h);
  endtask

  // Rising edge on channel c; if a full period has been seen, queue its expected verdict.
  task automatic do_rise(input int c);
    int   per;
    int   hi;
    bit   pass;
    exp_t e;
    per = cyc - last_rise[c];
    hi  = last_fall[c] - last_rise[c];
    if (armed[c] && per < int'(TIMEOUT)) begin
      pass = (absd(per, ep[c]) <= int'(TOL)) && (absd(hi, eh[c]) <= int'(TOL));
      m_ok[c] = pass;
      if (!pass) m_fail[c] = 1'b1;
      e.ok   = pass;
      e.fail = m_fail[c];
      sb_q[c].push_back(e);
    end
    armed[c]     = 1'b1;
    last_rise[c] = cyc;
    bus.sig_in[c] = 1'b1;
  endtask

  task automatic do_fall(input int c);
    last_fall[c]  = cyc;
    bus.sig_in[c] = 1'b0;
  endtask

  task automatic pulse(input int c, input int h, input int l);
    do_rise(c);
    repeat (h) @(negedge clk);
    do_fall(c);
    repeat (l) @(negedge clk);
  endtask

  task automatic run_chan(input int c);
    int h;
    h = 50 * (c + 1);
    repeat (3) pulse(c, h, h);
    do_rise(c);
  endtask

  task automatic disarm_all();
    for (int c = 0; c < int'(NUM_CH); c++) armed[c] = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (bus.eval_stb[i] === 1'b1) begin
          if (i == 0 && first_stb_cyc < 0) first_stb_cyc = cyc;
          if (sb_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_eval ch%0d: got eval_stb=1 ok=%b fail=%b expected no eval (cycle %0d)",
                     i, bus.ch_ok[i], bus.ch_fail[i], cyc);
          end else begin
            e = sb_q[i].pop_front();
            chk($sformatf("eval_ch%0d_ok_fail", i), {30'b0, bus.ch_ok[i], bus.ch_fail[i]},
                {30'b0, e.ok, e.fail});
          end
        end
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    first_stb_cyc = -1;
    rise2_cyc     = 0;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.clear_in  = 1'b0;
    bus.sig_in    = '0;
    bus.exp_period = '0;
    bus.exp_high   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      armed[c] = 1'b0; m_ok[c] = 1'b0; m_fail[c] = 1'b0;
      last_rise[c] = 0; last_fall[c] = 0;
      set_exp(c, 100 * (c + 1), 50 * (c + 1));
    end
    set_exp(0, 100, 40);

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ok",    32'(bus.ch_ok),    32'h0);
    chk("reset_fail",  32'(bus.ch_fail),  32'h0);
    chk("reset_stuck", 32'(bus.ch_stuck), 32'h0);
    chk("reset_stb",   32'(bus.eval_stb), 32'h0);
    reset      = 1'b0;
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal, tolerance-edge and out-of-tolerance periods on channel 0
    pulse(0, 40, 60);
    rise2_cyc = cyc;
    pulse(0, 40, 60);
    pulse(0, 40, 60);
    pulse(0, 44, 60);
    pulse(0, 40, 65);
    pulse(0, 40, 60);
    do_rise(0);
    repeat (40) @(negedge clk);
    do_fall(0);
    repeat (60) @(negedge clk);
    chk("first_eval_latency", 32'(first_stb_cyc - rise2_cyc), 32'd3);
    chk("ch0_ok_after_recovery",  32'(bus.ch_ok[0]),   32'd1);
    chk("ch0_fail_sticky",        32'(bus.ch_fail[0]), 32'd1);

    // Stuck detection on channel 2 held low
    @(negedge clk);
    bus.enable = 1'b0;
    disarm_all();
    @(negedge clk);
    chk("stuck_cleared_by_disable", 32'(bus.ch_stuck), 32'h0);
    bus.enable = 1'b1;
    repeat (1000) @(negedge clk);
    chk("ch2_stuck_before_timeout", 32'(bus.ch_stuck[2]), 32'd0);
    @(negedge clk);
    chk("ch2_stuck_at_timeout", 32'(bus.ch_stuck[2]), 32'd1);
    repeat (5) @(negedge clk);
    do_rise(2);
    repeat (4) @(negedge clk);
    chk("ch2_stuck_released", 32'(bus.ch_stuck[2]), 32'd0);
    repeat (146) @(negedge clk);
    do_fall(2);
    repeat (150) @(negedge clk);
    pulse(2, 150, 150);
    pulse(2, 150, 150);
    do_rise(2);
    repeat (150) @(negedge clk);
    do_fall(2);
    repeat (10) @(negedge clk);
    chk("ch2_ok_after_stuck", 32'(bus.ch_ok[2]), 32'd1);

    // Clear behaviour on channel 0
    pulse(0, 40, 60);
    do_rise(0);
    repeat (10) @(negedge clk);
    bus.clear_in = 1'b1;
    @(negedge clk);
    bus.clear_in = 1'b0;
    m_ok[0]   = 1'b0;
    m_fail[0] = 1'b0;
    chk("clear_ok",   32'(bus.ch_ok[0]),   32'd0);
    chk("clear_fail", 32'(bus.ch_fail[0]), 32'd0);
    repeat (29) @(negedge clk);
    do_fall(0);
    repeat (60) @(negedge clk);
    do_rise(0);
    repeat (40) @(negedge clk);
    do_fall(0);
    repeat (70) @(negedge clk);
    do_rise(0);
    repeat (2) @(negedge clk);
    bus.clear_in = 1'b1;
    @(negedge clk);
    bus.clear_in = 1'b0;
    chk("clear_vs_failing_eval", 32'(bus.ch_fail[0]), 32'd1);
    repeat (37) @(negedge clk);
    do_fall(0);
    repeat (60) @(negedge clk);
    do_rise(0);

    // Disable while measuring the high phase
    repeat (20) @(negedge clk);
    bus.enable = 1'b0;
    disarm_all();
    repeat (5) @(negedge clk);
    chk("disable_stuck",   32'(bus.ch_stuck),   32'h0);
    chk("disable_ok_hold", 32'(bus.ch_ok[0]),   32'(m_ok[0]));
    chk("disable_fail_hold", 32'(bus.ch_fail[0]), 32'(m_fail[0]));
    do_fall(0);
    repeat (5) @(negedge clk);
    bus.enable = 1'b1;
    repeat (10) @(negedge clk);
    pulse(0, 40, 60);
    pulse(0, 40, 60);
    pulse(0, 40, 60);
    do_rise(0);
    repeat (40) @(negedge clk);
    do_fall(0);
    repeat (10) @(negedge clk);

    // All channels concurrently, then reset mid-run
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    disarm_all();
    for (int c = 0; c < int'(NUM_CH); c++) begin
      m_ok[c] = 1'b0;
      m_fail[c] = 1'b0;
    end
    set_exp(0, 100, 50);
    repeat (5) @(negedge clk);
    fork
      run_chan(0);
      run_chan(1);
      run_chan(2);
      run_chan(3);
      run_chan(4);
      run_chan(5);
      run_chan(6);
      run_chan(7);
    join
    repeat (10) @(negedge clk);
    chk("all_ch_ok",   32'(bus.ch_ok),   32'hFF);
    chk("all_ch_fail", 32'(bus.ch_fail), 32'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_ok",    32'(bus.ch_ok),    32'h0);
    chk("midrun_reset_fail",  32'(bus.ch_fail),  32'h0);
    chk("midrun_reset_stuck", 32'(bus.ch_stuck), 32'h0);
    chk("midrun_reset_stb",   32'(bus.eval_stb), 32'h0);
    reset = 1'b0;
    bus.sig_in = '0;
    repeat (20) @(negedge clk);

    for (int c = 0; c < int'(NUM_CH); c++)
      chk($sformatf("scoreboard_drained_ch%0d", c), 32'(sb_q[c].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
